eeprom_loader: RTL and testbench

Boot-time copier that streams a program image out of the serial EEPROM, byte by byte, through the existing `eeprom` reader. It assembles the bytes into little-endian 32-bit words and writes them into RAM over the memory bus. It sits upstream of the `riscv` core: the core stays in its delay/reset states until `done` rises, then fetches from `LOAD_BASE`. It drives the same bus signals the core drives, and the top level muxes the two masters on `busy`.

---
 rtl/eeprom_loader_pkg.sv | 5 +
 rtl/eeprom_loader_sync2.sv | 14 +
 rtl/eeprom_loader.sv | 112 +++++++++++
 tb/tb_eeprom_loader.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/eeprom_loader_pkg.sv
// eeprom_loader_pkg: shared state encoding and bus constants for the EEPROM boot loader
package eeprom_loader_pkg;
  typedef enum logic [2:0] {IDLE, REQ, RELEASE, WRITE, WRITE_END, DONE} state_t;
  localparam logic [3:0] MASK_ALL = 4'b0000;
endpackage

// File: rtl/eeprom_loader_sync2.sv
// sync2: two-flop synchroniser for a single asynchronous level
module sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);
  logic r_meta, r_q;
  // shift the async level through two flops before anyone looks at it
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {r_q, r_meta} <= 2'b00;
    else {r_q, r_meta} <= {r_meta, i_d};
  assign o_q = r_q;
endmodule

// File: rtl/eeprom_loader.sv
// eeprom_loader: copies the EEPROM image into RAM as little-endian 32-bit words at boot
module eeprom_loader
  import eeprom_loader_pkg::*;
#(
  parameter int          WORD_COUNT  = 512,
  parameter logic [10:0] EEPROM_BASE = 11'h000,
  parameter logic [15:0] LOAD_BASE   = 16'hc000,
  parameter int          TIMEOUT     = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [10:0] eeprom_address,
  output logic        eeprom_strobe,
  input  logic        eeprom_ready,
  input  logic [7:0]  eeprom_data,
  output logic [15:0] mem_address,
  output logic [31:0] mem_write,
  output logic [3:0]  mem_write_mask,
  output logic        mem_bus_enable,
  output logic        mem_write_enable
);
  localparam int WW = WORD_COUNT > 1 ? $clog2(WORD_COUNT) : 1;
  state_t r_state, w_next;
  logic w_rdy, w_wait, w_tmo, w_last;
  logic r_strobe, r_done, r_error;
  logic [WW-1:0] r_word;
  logic [1:0] r_byte;
  logic [15:0] r_tmo;
  logic [10:0] r_eaddr;
  logic [15:0] r_maddr;
  logic [31:0] r_wdata;

  sync2 u_sync (.clk(clk), .reset_n(reset_n), .i_d(eeprom_ready), .o_q(w_rdy));

  assign w_wait = (r_state == REQ && !w_rdy) || (r_state == RELEASE && w_rdy);
  assign w_tmo  = w_wait && r_tmo == 16'(TIMEOUT - 1);
  assign w_last = r_word == WW'(WORD_COUNT - 1);

  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;

  // next state and the bus controls decoded from the current state
  always_comb begin
    w_next = r_state;
    busy = r_state != IDLE && r_state != DONE;
    mem_bus_enable = r_state == WRITE;
    mem_write_enable = r_state == WRITE;
    case (r_state)
      IDLE:      w_next = start ? REQ : IDLE;
      REQ:       w_next = w_tmo ? IDLE : w_rdy ? RELEASE : REQ;
      RELEASE:   w_next = w_tmo ? IDLE : w_rdy ? RELEASE : r_byte == 2'd3 ? WRITE : REQ;
      WRITE:     w_next = WRITE_END;
      WRITE_END: w_next = w_last ? DONE : REQ;
      DONE:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // counters, address registers, byte assembly and sticky status flags
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_strobe <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_word   <= '0;
      r_byte   <= 2'd0;
      r_tmo    <= 16'd0;
      r_eaddr  <= 11'd0;
      r_maddr  <= 16'd0;
      r_wdata  <= 32'd0;
    end else begin
      r_strobe <= r_state == REQ && !w_rdy && !w_tmo;
      r_tmo    <= w_wait && !w_tmo ? r_tmo + 16'd1 : 16'd0;
      if (w_tmo) r_error <= 1'b1;
      case (r_state)
        IDLE: if (start) begin
          r_done  <= 1'b0;
          r_error <= 1'b0;
          r_eaddr <= EEPROM_BASE;
          r_maddr <= LOAD_BASE;
          r_word  <= '0;
          r_byte  <= 2'd0;
        end
        REQ: if (w_rdy) r_wdata[{r_byte, 3'b000} +: 8] <= eeprom_data;
        RELEASE: if (!w_rdy) begin
          r_eaddr <= r_eaddr + 11'd1;
          if (r_byte != 2'd3) r_byte <= r_byte + 2'd1;
        end
        WRITE_END: if (w_last) r_done <= 1'b1;
        else begin
          r_word  <= r_word + 1'b1;
          r_maddr <= r_maddr + 16'd4;
          r_byte  <= 2'd0;
        end
        default: ;
      endcase
    end

  assign done           = r_done;
  assign error          = r_error;
  assign eeprom_address = r_eaddr;
  assign eeprom_strobe  = r_strobe;
  assign mem_address    = r_maddr;
  assign mem_write      = r_wdata;
  assign mem_write_mask = MASK_ALL;
endmodule

// File: tb/tb_eeprom_loader.sv
// tb_eeprom_loader: two loaders (4-word, 1-word) fed by behavioural EEPROMs, checked against an image model
module tb_eeprom_loader;
  localparam logic [15:0] LB = 16'hc000;
  typedef struct {logic [15:0] addr; logic [31:0] data; logic [3:0] mask; logic we;} wr_t;
  typedef struct {logic [15:0] addr; logic [31:0] data;} vec_t;

  logic clk = 0, raw_clk = 0, reset_n = 0;
  always #4 clk = ~clk;
  always #1 raw_clk = ~raw_clk;

  logic a_start = 0, a_busy, a_done, a_error, a_strobe, a_ready = 0, a_en, a_we;
  logic [10:0] a_eaddr;
  logic [7:0] a_edata = 0;
  logic [15:0] a_maddr;
  logic [31:0] a_wdata;
  logic [3:0] a_mask;
  logic b_start = 0, b_busy, b_done, b_error, b_strobe, b_ready = 0, b_en, b_we;
  logic [10:0] b_eaddr;
  logic [7:0] b_edata = 0;
  logic [15:0] b_maddr;
  logic [31:0] b_wdata;
  logic [3:0] b_mask;

  eeprom_loader #(.WORD_COUNT(4), .EEPROM_BASE(11'h000), .LOAD_BASE(LB), .TIMEOUT(100)) u_a (
    .clk(clk), .reset_n(reset_n), .start(a_start), .busy(a_busy), .done(a_done), .error(a_error),
    .eeprom_address(a_eaddr), .eeprom_strobe(a_strobe), .eeprom_ready(a_ready), .eeprom_data(a_edata),
    .mem_address(a_maddr), .mem_write(a_wdata), .mem_write_mask(a_mask),
    .mem_bus_enable(a_en), .mem_write_enable(a_we));

  eeprom_loader #(.WORD_COUNT(1)) u_b (
    .clk(clk), .reset_n(reset_n), .start(b_start), .busy(b_busy), .done(b_done), .error(b_error),
    .eeprom_address(b_eaddr), .eeprom_strobe(b_strobe), .eeprom_ready(b_ready), .eeprom_data(b_edata),
    .mem_address(b_maddr), .mem_write(b_wdata), .mem_write_mask(b_mask),
    .mem_bus_enable(b_en), .mem_write_enable(b_we));

  logic [7:0] mem_a [2048];
  logic [7:0] mem_b [2048];
  int lat_lo = 1, lat_hi = 3, a_cnt = 1, a_lat = 1, b_cnt = 1, strobe_bad = 0;
  bit ready_en = 1;
  logic a_sp = 0;
  logic [10:0] aq[$];
  wr_t wq_a[$], wq_b[$];
  int checks = 0, errors = 0;

  // EEPROM A in the raw clock domain: random response delay, drops ready once strobe falls
  always @(posedge raw_clk) begin
    if (a_strobe && !a_sp) begin
      aq.push_back(a_eaddr);
      if (a_ready) strobe_bad++;
    end
    a_sp <= a_strobe;
    if (!a_strobe) begin
      a_ready <= 0;
      a_cnt <= 1;
      a_lat <= int'($urandom_range(lat_hi, lat_lo));
    end else if (!a_ready && ready_en) begin
      if (a_cnt >= a_lat) begin
        a_ready <= 1;
        a_edata <= mem_a[a_eaddr];
      end else a_cnt <= a_cnt + 1;
    end
  end

  // EEPROM B: fixed short delay
  always @(posedge raw_clk) begin
    if (!b_strobe) begin
      b_ready <= 0;
      b_cnt <= 1;
    end else if (!b_ready) begin
      if (b_cnt >= 2) begin
        b_ready <= 1;
        b_edata <= mem_b[b_eaddr];
      end else b_cnt <= b_cnt + 1;
    end
  end

  // record every bus write away from the active edge
  always @(negedge clk) begin
    if (a_en) wq_a.push_back('{a_maddr, a_wdata, a_mask, a_we});
    if (b_en) wq_b.push_back('{b_maddr, b_wdata, b_mask, b_we});
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pulse_a();
    @(negedge clk);
    a_start = 1;
    @(negedge clk);
    a_start = 0;
  endtask

  task automatic wait_a(input string nm, input int limit);
    int n = 0;
    while (!a_done && !a_error && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " finished"}, 32'(n < limit), 1);
  endtask

  task automatic check_a(input string nm);
    chk({nm, " writes"}, wq_a.size(), 4);
    for (int k = 0; k < 4 && k < wq_a.size(); k++) begin
      chk({nm, " addr"}, wq_a[k].addr, LB + 16'(4 * k));
      chk({nm, " data"}, wq_a[k].data, {mem_a[4*k+3], mem_a[4*k+2], mem_a[4*k+1], mem_a[4*k]});
      chk({nm, " mask/we"}, {wq_a[k].mask, wq_a[k].we}, 5'b00001);
    end
    chk({nm, " done"}, {a_done, a_busy, a_error}, 3'b100);
    chk({nm, " ee reqs"}, aq.size(), 16);
    for (int i = 0; i < 16 && i < aq.size(); i++) chk({nm, " ee addr"}, aq[i], i);
  endtask

  task automatic check_a_zero(input string nm);
    chk({nm, " flags"}, {a_busy, a_done, a_error, a_strobe, a_en, a_we}, 0);
    chk({nm, " eaddr"}, a_eaddr, 0);
    chk({nm, " maddr"}, a_maddr, 0);
    chk({nm, " wdata"}, a_wdata, 0);
    chk({nm, " mask"}, a_mask, 0);
  endtask

  initial begin
    vec_t tab [4];
    int n;
    tab = '{'{16'hc000, 32'h03020100}, '{16'hc004, 32'h07060504},
            '{16'hc008, 32'h0b0a0908}, '{16'hc00c, 32'h0f0e0d0c}};
    for (int i = 0; i < 2048; i++) begin
      mem_a[i] = 8'(i);
      mem_b[i] = 8'h00;
    end
    mem_b[0] = 8'h13;
    mem_b[2] = 8'h05;
    #3;
    check_a_zero("reset");
    #20 reset_n = 1;

    // single word on the 1-word loader
    @(negedge clk);
    b_start = 1;
    @(negedge clk);
    b_start = 0;
    n = 0;
    while (!b_done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("single finished", 32'(n < 2000), 1);
    repeat (3) @(negedge clk);
    chk("single writes", wq_b.size(), 1);
    if (wq_b.size() > 0) begin
      chk("single addr", wq_b[0].addr, 16'hc000);
      chk("single data", wq_b[0].data, 32'h00050013);
      chk("single mask/we", {wq_b[0].mask, wq_b[0].we}, 5'b00001);
    end
    chk("single done held", {b_done, b_busy, b_error}, 3'b100);

    // multi-word counting pattern against the fixed table
    wq_a.delete();
    aq.delete();
    pulse_a();
    wait_a("pattern", 3000);
    chk("pattern writes", wq_a.size(), 4);
    for (int i = 0; i < 4 && i < wq_a.size(); i++) begin
      chk("pattern addr", wq_a[i].addr, tab[i].addr);
      chk("pattern data", wq_a[i].data, tab[i].data);
    end
    check_a("pattern");

    // random image, random latency up to 200 raw cycles; second run gets a start while busy
    lat_lo = 1;
    lat_hi = 200;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) mem_a[i] = 8'($urandom);
      wq_a.delete();
      aq.delete();
      pulse_a();
      if (r == 1) begin
        n = 0;
        while (wq_a.size() < 1 && n < 5000) begin
          @(negedge clk);
          n++;
        end
        repeat (3) @(negedge clk);
        pulse_a();
      end
      wait_a("random", 8000);
      check_a("random");
    end
    chk("strobe while ready", strobe_bad, 0);

    // timeout: ready never comes
    lat_lo = 1;
    lat_hi = 3;
    ready_en = 0;
    wq_a.delete();
    aq.delete();
    pulse_a();
    n = 0;
    while (!a_error && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("timeout cycles", n, 100);
    chk("timeout flags", {a_error, a_strobe, a_busy, a_done}, 4'b1000);
    chk("timeout writes", wq_a.size(), 0);
    ready_en = 1;
    aq.delete();
    pulse_a();
    chk("retry error cleared", {a_error, a_busy}, 2'b01);
    wait_a("retry", 3000);
    check_a("retry");

    // reset during word 2 then restart
    wq_a.delete();
    aq.delete();
    pulse_a();
    n = 0;
    while (wq_a.size() < 2 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("mid reached word 2", 32'(wq_a.size() >= 2), 1);
    repeat (5) @(negedge clk);
    #1 reset_n = 0;
    #1;
    check_a_zero("async reset");
    #9 reset_n = 1;
    wq_a.delete();
    aq.delete();
    pulse_a();
    wait_a("restart", 3000);
    check_a("restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
